// File: rtl/dataflow_sched.sv
// Operand batcher for the tagged-word crossbar: packs up to NUM_LANES operands,
// tags each slot with a rotated lane number, and presents the batch under valid/ready.

module dataflow_sched_lane #(
  parameter int NUM_LANES = 13,
  parameter int DATA_W    = 16,
  parameter int TAG_W     = 4,
  parameter int CNT_W     = 4,
  parameter int LANE      = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic                    clr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic [CNT_W-1:0]        fill_cnt,
  input  logic [TAG_W-1:0]        rot,
  output logic [TAG_W+DATA_W-1:0] word
);
  localparam logic [TAG_W:0]   LANE_V = (TAG_W+1)'(LANE);
  localparam logic [TAG_W:0]   N_V    = (TAG_W+1)'(NUM_LANES);
  localparam logic [CNT_W-1:0] LANE_C = CNT_W'(LANE);

  logic [DATA_W-1:0] slot;
  logic [TAG_W:0]    sum, wrapped;
  logic [TAG_W-1:0]  tag;

  always_ff @(posedge clk) begin
    if (rst || clr) slot <= '0;
    else if (wr_en) slot <= wr_data;
  end

  // (lane + rot) mod N via a single compare-and-subtract; both terms are < N
  always_comb begin
    sum     = LANE_V + {1'b0, rot};
    wrapped = (sum >= N_V) ? (sum - N_V) : sum;
    tag     = TAG_W'(wrapped + 1'b1);
  end

  assign word = (fill_cnt > LANE_C) ? {tag, slot} : '0;
endmodule

module dataflow_sched #(
  parameter int NUM_LANES = 13,
  parameter int DATA_W    = 16,
  parameter int TAG_W     = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [DATA_W-1:0]                   in_data,
  input  logic                                in_valid,
  input  logic                                in_last,
  output logic                                in_ready,
  input  logic                                cfg_rot_en,
  input  logic                                cfg_rot_load,
  input  logic [TAG_W-1:0]                    cfg_rot_init,
  output logic [NUM_LANES*(TAG_W+DATA_W)-1:0] out_words,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [TAG_W-1:0]                    rot,
  output logic [7:0]                          batch_cnt
);
  localparam int WW    = TAG_W + DATA_W;
  localparam int CNT_W = $clog2(NUM_LANES + 1);

  typedef enum logic [1:0] {IDLE, FILL, ISSUE} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   fill_cnt;
  logic               accept, closing, issue_fire;

  assign accept     = in_valid && in_ready;
  assign closing    = accept && (in_last || fill_cnt == CNT_W'(NUM_LANES - 1));
  assign issue_fire = (state == ISSUE) && out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (closing)     state_d = ISSUE;
        else if (accept) state_d = FILL;
      end
      FILL: begin
        in_ready = 1'b1;
        if (closing) state_d = ISSUE;
      end
      ISSUE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt  <= '0;
      rot       <= '0;
      batch_cnt <= '0;
    end else begin
      if (accept) fill_cnt <= fill_cnt + 1'b1;
      if (issue_fire) begin
        fill_cnt  <= '0;
        batch_cnt <= batch_cnt + 8'd1;
        if (cfg_rot_en)
          rot <= (rot == TAG_W'(NUM_LANES - 1)) ? '0 : rot + 1'b1;
      end
      // Loads only between batches so a batch never mixes two rotations
      if (state == IDLE && cfg_rot_load)
        rot <= (cfg_rot_init < TAG_W'(NUM_LANES)) ? cfg_rot_init : '0;
    end
  end

  for (genvar s = 0; s < NUM_LANES; s++) begin : g_lane
    dataflow_sched_lane #(
      .NUM_LANES(NUM_LANES), .DATA_W(DATA_W), .TAG_W(TAG_W),
      .CNT_W(CNT_W), .LANE(s)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (accept && fill_cnt == CNT_W'(s)),
      .clr      (issue_fire),
      .wr_data  (in_data),
      .fill_cnt (fill_cnt),
      .rot      (rot),
      .word     (out_words[s*WW +: WW])
    );
  end
endmodule

// File: tb/tb_dataflow_sched.sv
// Directed test-plan steps followed by a random phase, all checked cycle by cycle
// against a queue-based model of the batching and tagging rules.

module tb_dataflow_sched;
  localparam int N  = 13;
  localparam int DW = 16;
  localparam int TW = 4;
  localparam int WW = TW + DW;
  localparam int OW = N * WW;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid, in_last, in_ready;
  logic          cfg_rot_en, cfg_rot_load;
  logic [TW-1:0] cfg_rot_init;
  logic [OW-1:0] out_words;
  logic          out_valid, out_ready;
  logic [TW-1:0] rot;
  logic [7:0]    batch_cnt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mq[$];
  bit            m_pend;
  int            m_rot;
  logic [7:0]    m_cnt;
  logic [OW-1:0] snap;

  dataflow_sched #(.NUM_LANES(N), .DATA_W(DW), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .cfg_rot_en(cfg_rot_en), .cfg_rot_load(cfg_rot_load),
    .cfg_rot_init(cfg_rot_init), .out_words(out_words), .out_valid(out_valid),
    .out_ready(out_ready), .rot(rot), .batch_cnt(batch_cnt)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] model_words();
    logic [OW-1:0] w = '0;
    for (int s = 0; s < mq.size(); s++)
      w[s*WW +: WW] = {TW'(((s + m_rot) % N) + 1), mq[s]};
    return w;
  endfunction

  // Model advance for the edge just taken, using the inputs that were held across it
  task automatic model_update();
    if (rst) begin
      mq.delete(); m_pend = 0; m_rot = 0; m_cnt = 0;
    end else if (m_pend) begin
      if (out_ready) begin
        mq.delete(); m_pend = 0; m_cnt++;
        if (cfg_rot_en) m_rot = (m_rot + 1) % N;
      end
    end else begin
      if (cfg_rot_load && mq.size() == 0) m_rot = (cfg_rot_init < N) ? int'(cfg_rot_init) : 0;
      if (in_valid) begin
        mq.push_back(in_data);
        if (mq.size() == N || in_last) m_pend = 1;
      end
    end
  endtask

  task automatic check_model();
    cmp("in_ready", in_ready, !m_pend);
    cmp("out_valid", out_valid, m_pend);
    cmp("rot", rot, m_rot);
    cmp("batch_cnt", batch_cnt, m_cnt);
    cmp("out_words", out_words, model_words());
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_model();
  endtask

  task automatic put(input logic [DW-1:0] d, input logic last);
    in_valid = 1'b1; in_data = d; in_last = last;
    cycle();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic load_rot(input logic [TW-1:0] v);
    cfg_rot_load = 1'b1; cfg_rot_init = v;
    cycle();
    cfg_rot_load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    cfg_rot_en = 1'b1; cfg_rot_load = 1'b0; cfg_rot_init = '0; out_ready = 1'b1;
    mq.delete(); m_pend = 0; m_rot = 0; m_cnt = 0;
    cycle();
    rst = 1'b0;
    cmp("reset_words", out_words, '0);
    cmp("reset_ready", in_ready, 1'b1);

    // Full batch at rot 0
    for (int s = 0; s < N; s++) put(DW'(16'h0100 + s), 1'b0);
    cmp("t1_valid", out_valid, 1'b1);
    for (int s = 0; s < N; s++) begin
      logic [WW-1:0] e;
      e = {TW'(s + 1), DW'(16'h0100 + s)};
      cmp("t1_slot", out_words[s*WW +: WW], e);
    end
    cycle();
    cmp("t1_batch", batch_cnt, 8'd1);
    cmp("t1_rot", rot, 4'd1);

    // Load 12, full batch, rotation wraps after issue
    load_rot(4'd12);
    cmp("t2_rot", rot, 4'd12);
    for (int s = 0; s < N; s++) put(DW'($urandom), 1'b0);
    cmp("t2_tag0", out_words[0*WW+DW +: TW], 4'd13);
    cmp("t2_tag1", out_words[1*WW+DW +: TW], 4'd1);
    cmp("t2_tag12", out_words[12*WW+DW +: TW], 4'd12);
    cycle();
    cmp("t2_wrap", rot, 4'd0);

    // Short batch at rot 5
    load_rot(4'd5);
    put(16'hAAAA, 1'b0); put(16'hBBBB, 1'b0); put(16'hCCCC, 1'b1);
    cmp("t3_valid", out_valid, 1'b1);
    cmp("t3_s0", out_words[0 +: WW], {4'd6, 16'hAAAA});
    cmp("t3_s1", out_words[WW +: WW], {4'd7, 16'hBBBB});
    cmp("t3_s2", out_words[2*WW +: WW], {4'd8, 16'hCCCC});
    cmp("t3_upper", out_words[OW-1:3*WW], '0);
    cycle();

    // Backpressure: words frozen, operands and rotation loads refused
    out_ready = 1'b0;
    for (int s = 0; s < N; s++) put(DW'($urandom), 1'b0);
    snap = out_words;
    in_valid = 1'b1; cfg_rot_load = 1'b1; cfg_rot_init = 4'd3;
    for (int i = 0; i < 10; i++) begin
      in_data = DW'($urandom);
      cycle();
      cmp("t4_stable", out_words, snap);
      cmp("t4_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0; cfg_rot_load = 1'b0;
    out_ready = 1'b1;
    cycle();
    cmp("t4_rot", rot, 4'd7);

    // Reset mid-fill
    for (int s = 0; s < 7; s++) put(DW'($urandom), 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cmp("t5_valid", out_valid, 1'b0);
    cmp("t5_ready", in_ready, 1'b1);
    cmp("t5_words", out_words, '0);
    cmp("t5_rot", rot, 4'd0);
    cmp("t5_cnt", batch_cnt, 8'd0);
    for (int s = 0; s < N; s++) put(DW'(16'h5000 + s), 1'b0);
    cmp("t5_slot0", out_words[0 +: WW], {4'd1, 16'h5000});
    cycle();

    // Out-of-range init clamps to 0
    load_rot(4'd7);
    load_rot(4'd14);
    cmp("t6_rot", rot, 4'd0);

    // Random phase
    for (int i = 0; i < 600; i++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      in_data      = DW'($urandom);
      in_last      = ($urandom_range(0, 5) == 0);
      out_ready    = ($urandom_range(0, 1) == 1);
      cfg_rot_en   = ($urandom_range(0, 3) != 0);
      cfg_rot_load = ($urandom_range(0, 7) == 0);
      cfg_rot_init = TW'($urandom_range(0, 15));
      rst          = ($urandom_range(0, 99) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dataflow_sched.md
# dataflow_sched

Sequencer that feeds the 13-lane tagged-word crossbar (`DataFlow`) in the convolution layer. It accepts a stream of 16-bit operands and packs them into batches of up to `NUM_LANES` slots. Each slot gets a 4-bit destination tag, rotated per batch so successive batches land on shifted lanes, as the sliding convolution window requires. Each batch is presented to the crossbar under a valid/ready handshake. Unused slots carry tag 0, which the crossbar ignores, so their lanes read zero.

## Interface
Parameters:
- `NUM_LANES`, 13: slots per batch and crossbar lanes. Legal range 2..15.
- `DATA_W`, 16: operand width.
- `TAG_W`, 4: tag width. Packed word is `TAG_W+DATA_W` = 20 bits, with the tag in [19:16] and data in [15:0].

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset. Synchronous, active-high.
- `in_data`, in, `DATA_W`: operand.
- `in_valid`, in, 1: operand valid.
- `in_last`, in, 1: last operand of a batch. Qualified by `in_valid && in_ready`.
- `in_ready`, out, 1: scheduler can accept an operand.
- `cfg_rot_en`, in, 1: advance the rotation after each issued batch.
- `cfg_rot_load`, in, 1: single-cycle pulse that loads the rotation from `cfg_rot_init`.
- `cfg_rot_init`, in, `TAG_W`: initial rotation value.
- `out_words`, out, `NUM_LANES*(TAG_W+DATA_W)`: packed tagged words. Slot s occupies bits [s*20 +: 20] and drives crossbar `data_in<s>`.
- `out_valid`, out, 1: batch is presented.
- `out_ready`, in, 1: downstream accepts the batch.
- `rot`, out, `TAG_W`: current rotation, 0..NUM_LANES-1.
- `batch_cnt`, out, 8: number of issued batches, wraps at 255→0.

## Operation
States:
- IDLE: no operands buffered.
- FILL: 1..NUM_LANES-1 operands buffered.
- ISSUE: batch presented on `out_words`.

Handshake and state transitions:
- `in_ready` = 1 in IDLE and FILL, 0 in ISSUE.
- Accepted operand: written to slot `fill_cnt`, then `fill_cnt` increments.
- Transition to ISSUE when the accepted operand makes `fill_cnt` = NUM_LANES, or when it carries `in_last`.
- Otherwise IDLE→FILL on the first accepted operand.
- ISSUE with `out_valid && out_ready`:
  - Clear all slots and set `fill_cnt`=0.
  - Increment `batch_cnt`.
  - If `cfg_rot_en`, set `rot` ← (rot+1 == NUM_LANES) ? 0 : rot+1.
  - Go to IDLE.

Tag rule, for slot s < `fill_cnt`:
- tag = ((s + rot) mod NUM_LANES) + 1, giving range 1..NUM_LANES. Computed with compare-and-subtract, no divider.
- Tags within one batch are distinct, so no crossbar collision is possible.
- Slots s ≥ `fill_cnt` output tag 0 and data 0.

Rotation load:
- `cfg_rot_load` is honored only in IDLE.
- `rot` ← `cfg_rot_init` if `cfg_rot_init` < NUM_LANES, else 0.
- The pulse is ignored in FILL and ISSUE, so the rotation is never torn mid-batch.

Other rules:
- `out_words`, `rot` and `fill_cnt` are held stable while `out_valid && !out_ready`.
- `in_last` with `in_valid` low, or with `in_ready` low, has no effect.

## Timing
- Reset values: state IDLE, `fill_cnt` 0, all slots 0, `in_ready` 1, `out_valid` 0, `out_words` all 0, `rot` 0, `batch_cnt` 0.
- Reset asserted mid-FILL or mid-ISSUE discards the partial or presented batch. All registers take their reset values on the next edge.
- `out_valid` rises the cycle after the closing operand is accepted (1-cycle latency).
- `out_words` is fully registered: no combinational path from the `in_*` ports.
- Issue is accepted on the edge where `out_valid && out_ready`. `in_ready` returns to 1 the following cycle, so there is one bubble between batches.
- Throughput: full batches at one operand per cycle give 13 fill cycles plus at least 1 issue cycle.
- `out_ready` may be held high before `out_valid`; the batch then completes in 1 ISSUE cycle.
- `rot` and `batch_cnt` update on the same edge as the issue handshake.

## Test plan
- Reset, then 13 operands 0x0100..0x010C with `rot`=0 and `out_ready`=1. Required: `out_valid` one cycle after the 13th operand; slot s = {s+1, 0x0100+s}; `batch_cnt`=1. With `cfg_rot_en`=1, `rot`=1 after the issue.
- `cfg_rot_load` with init 12 in IDLE, then a full batch. Required: slot 0 tag 13, slot 1 tag 1, slot 12 tag 12. After the issue with `cfg_rot_en`=1, `rot` wraps to 0.
- Short batch of 3 operands (0xAAAA, 0xBBBB, 0xCCCC) with `in_last` on the 3rd, `rot`=5. Required: tags 6, 7, 8; slots 3..12 all 0.
- Backpressure: `out_ready`=0 for 10 cycles during ISSUE. Required: `out_words` stable, `in_ready`=0, operands offered meanwhile not accepted, `cfg_rot_load` ignored.
- `rst` pulsed after 7 operands accepted. Required: next cycle `out_valid`=0, `in_ready`=1, all outputs 0. A following full batch packs from slot 0.
- `cfg_rot_init`=14 (≥ NUM_LANES) loaded in IDLE. Required: `rot`=0.
